system_sequencer: RTL and testbench
===================================

Name: system_sequencer

Overview:
- Parametrised next-generation system control block.
- Sequences program load and CPU execution through the states IDLE, LOADING, EXECUTING, HALTED, FAULT and DEBUG.
- Arbitrates the single RAM port between the program loader, the CPU and a host debug port.
- Adds load/execution watchdogs, host abort, restart without global reset, and an execution cycle counter.

Parameters:
- MEM_ADDR_SIZE, 8: RAM address width.
- WORD_SIZE, 16: RAM data width.
- CYCLE_W, 32: execution cycle counter width.
- LOAD_TIMEOUT, 1024: maximum cycles allowed in LOADING; 0 disables the load watchdog.
- EXEC_TIMEOUT, 65536: maximum cycles allowed in EXECUTING; 0 disables the execution watchdog.
- RELOAD_ON_RESTART, 1: 1 = start from HALTED/FAULT goes to LOADING; 0 = goes straight to EXECUTING.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  host start/restart request, level sampled.
- abort  in  1  host abort request.
- load_complete  in  1  loader done.
- loader_addr  in  MEM_ADDR_SIZE  loader address.
- loader_wdata  in  WORD_SIZE  loader write data.
- loader_we  in  1  loader write enable.
- cpu_addr  in  MEM_ADDR_SIZE  CPU address.
- cpu_wdata  in  WORD_SIZE  CPU write data.
- cpu_we  in  1  CPU write enable.
- cpu_re  in  1  CPU read enable.
- cpu_halted  in  1  CPU has executed HALT.
- dbg_req  in  1  debug access request.
- dbg_we  in  1  debug write (0 = read).
- dbg_addr  in  MEM_ADDR_SIZE  debug address.
- dbg_wdata  in  WORD_SIZE  debug write data.
- mem_rdata  in  WORD_SIZE  RAM read data, valid the cycle after a read.
- mem_addr  out  MEM_ADDR_SIZE  RAM address (muxed).
- mem_wdata  out  WORD_SIZE  RAM write data (muxed).
- mem_we  out  1  RAM write enable (muxed).
- mem_re  out  1  RAM read enable (muxed).
- start_load  out  1  loader enable.
- cpu_execute  out  1  CPU run enable, registered.
- cpu_restart  out  1  one-cycle CPU soft-reset pulse.
- dbg_ack  out  1  debug access done, one-cycle pulse.
- dbg_rdata  out  WORD_SIZE  debug read data, valid while dbg_ack=1.
- state_out  out  3  current state: IDLE=0, LOADING=1, EXECUTING=2, HALTED=3, FAULT=4, DEBUG=5.
- fault_code  out  2  fault cause: 0 none, 1 load timeout, 2 exec timeout, 3 abort.
- exec_cycles  out  CYCLE_W  cycles spent in EXECUTING.

Behaviour:
- Reset values:
  - state = IDLE.
  - cpu_execute, cpu_restart, dbg_ack = 0.
  - dbg_rdata, fault_code, exec_cycles and the internal timer = 0.
- Memory mux (combinational):
  - LOADING: loader signals drive the RAM; mem_re = 0.
  - EXECUTING: CPU signals drive the RAM.
  - DEBUG: dbg_* drive the RAM on the first DEBUG cycle only.
  - All other states, including the second DEBUG cycle: mem_we = mem_re = 0, address/data = 0.
- start_load = (state == LOADING), combinational.
- cpu_execute is registered: 1 for every cycle the state register is EXECUTING, 0 otherwise.
- Transition priority per cycle: abort > completion (load_complete / cpu_halted) > watchdog.
- IDLE:
  - start -> LOADING; timer and exec_cycles cleared.
  - Else dbg_req -> DEBUG.
  - start has priority over dbg_req.
- LOADING:
  - abort -> FAULT, fault_code 3.
  - load_complete -> EXECUTING.
  - timer == LOAD_TIMEOUT-1 (LOAD_TIMEOUT != 0) -> FAULT, fault_code 1.
  - Timer increments each cycle and clears on exit.
- EXECUTING:
  - exec_cycles increments each cycle and saturates at all-ones.
  - abort -> FAULT, fault_code 3.
  - cpu_halted -> HALTED.
  - exec_cycles == EXEC_TIMEOUT-1 (EXEC_TIMEOUT != 0) -> FAULT, fault_code 2.
  - cpu_halted in the same cycle as the timeout -> HALTED.
- HALTED / FAULT:
  - start -> LOADING if RELOAD_ON_RESTART = 1, else EXECUTING.
  - On that exit: cpu_restart pulses 1 for exactly one cycle, fault_code clears to 0, exec_cycles clears to 0.
  - Else dbg_req -> DEBUG.
  - fault_code and exec_cycles hold while in these states.
- DEBUG:
  - Fixed 2 cycles. Cycle 1 issues the access; cycle 2 waits for read data.
  - The next edge returns to the originating state (IDLE/HALTED/FAULT), kept in an internal register.
  - On that edge dbg_ack = 1 and, for reads, dbg_rdata captures mem_rdata. Writes leave dbg_rdata unchanged.
  - dbg_req is ignored in LOADING and EXECUTING (no ack).
  - dbg_req still high after the ack starts a new access.
  - abort and start are ignored while in DEBUG.
- Illegal state encodings -> IDLE.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronous).

Test Plan:
1. Reset, then start=1 for 1 cycle; loader writes 4 words; load_complete at cycle 6 -> state 1→2; cpu_execute=1 the next cycle; cpu_halted after 10 cycles -> HALTED, exec_cycles=10, fault_code=0.
2. LOAD_TIMEOUT=8, load_complete never asserted -> FAULT exactly 8 cycles after entering LOADING, fault_code=1, mem_we=0 afterwards.
3. EXEC_TIMEOUT=16, cpu_halted asserted in the same cycle exec_cycles=15 -> HALTED, fault_code=0; rerun with cpu_halted low -> FAULT, fault_code=2.
4. Abort and cpu_halted asserted together during EXECUTING -> FAULT, fault_code=3; then start with RELOAD_ON_RESTART=0 -> cpu_restart 1-cycle pulse, state EXECUTING, fault_code=0, exec_cycles=0.
5. In HALTED: debug write 0xBEEF to addr 0x10, then debug read of 0x10 -> each dbg_ack 2 cycles after the request, dbg_rdata=0xBEEF, state returns to HALTED; dbg_req during EXECUTING -> no ack, CPU drives mem_addr.
6. Reset asserted mid-LOADING with loader_we=1 -> state=0, mem_we=0, cpu_execute=0 without waiting for a clock edge.

Source files
------------

// File: rtl/system_sequencer.sv
// System sequencer: walks a program through load, execution, halt/fault and
// host debug access, and owns the single RAM port on behalf of the loader,
// the CPU and the debug port.
module system_sequencer #(
  parameter int MEM_ADDR_SIZE     = 8,
  parameter int WORD_SIZE         = 16,
  parameter int CYCLE_W           = 32,
  parameter int LOAD_TIMEOUT      = 1024,
  parameter int EXEC_TIMEOUT      = 65536,
  parameter int RELOAD_ON_RESTART = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     load_complete,
  input  logic [MEM_ADDR_SIZE-1:0] loader_addr,
  input  logic [WORD_SIZE-1:0]     loader_wdata,
  input  logic                     loader_we,
  input  logic [MEM_ADDR_SIZE-1:0] cpu_addr,
  input  logic [WORD_SIZE-1:0]     cpu_wdata,
  input  logic                     cpu_we,
  input  logic                     cpu_re,
  input  logic                     cpu_halted,
  input  logic                     dbg_req,
  input  logic                     dbg_we,
  input  logic [MEM_ADDR_SIZE-1:0] dbg_addr,
  input  logic [WORD_SIZE-1:0]     dbg_wdata,
  input  logic [WORD_SIZE-1:0]     mem_rdata,
  output logic [MEM_ADDR_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0]     mem_wdata,
  output logic                     mem_we,
  output logic                     mem_re,
  output logic                     start_load,
  output logic                     cpu_execute,
  output logic                     cpu_restart,
  output logic                     dbg_ack,
  output logic [WORD_SIZE-1:0]     dbg_rdata,
  output logic [2:0]               state_out,
  output logic [1:0]               fault_code,
  output logic [CYCLE_W-1:0]       exec_cycles
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOADING   = 3'd1,
    ST_EXECUTING = 3'd2,
    ST_HALTED    = 3'd3,
    ST_FAULT     = 3'd4,
    ST_DEBUG     = 3'd5
  } state_t;

  localparam logic [1:0] FC_NONE  = 2'd0;
  localparam logic [1:0] FC_LOAD  = 2'd1;
  localparam logic [1:0] FC_EXEC  = 2'd2;
  localparam logic [1:0] FC_ABORT = 2'd3;

  // Last cycle index before each watchdog fires (only meaningful when enabled).
  localparam logic [31:0]        LOAD_LAST = 32'(LOAD_TIMEOUT - 1);
  localparam logic [CYCLE_W-1:0] EXEC_LAST = CYCLE_W'(EXEC_TIMEOUT - 1);

  // Where a start from HALTED/FAULT lands.
  localparam state_t RESTART_STATE = (RELOAD_ON_RESTART != 0) ? ST_LOADING : ST_EXECUTING;

  state_t      state;
  state_t      state_nxt;
  state_t      ret_state;     // state to return to after a debug access
  logic        dbg_second;    // high during the second (data-wait) debug cycle
  logic        dbg_rd;        // the current debug access is a read
  logic [31:0] timer;         // cycles spent in LOADING
  logic [1:0]  fault_nxt;
  logic        restart;
  logic        load_wd_hit;
  logic        exec_wd_hit;

  assign load_wd_hit = (LOAD_TIMEOUT != 0) && (timer == LOAD_LAST);
  assign exec_wd_hit = (EXEC_TIMEOUT != 0) && (exec_cycles == EXEC_LAST);

  assign start_load = (state == ST_LOADING);
  assign state_out  = state;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state, fault cause and restart decision; abort beats completion beats watchdog.
  always_comb begin
    state_nxt = state;
    fault_nxt = fault_code;
    restart   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start)        state_nxt = ST_LOADING;
        else if (dbg_req) state_nxt = ST_DEBUG;
      end
      ST_LOADING: begin
        if (abort) begin
          state_nxt = ST_FAULT;
          fault_nxt = FC_ABORT;
        end else if (load_complete) begin
          state_nxt = ST_EXECUTING;
        end else if (load_wd_hit) begin
          state_nxt = ST_FAULT;
          fault_nxt = FC_LOAD;
        end
      end
      ST_EXECUTING: begin
        if (abort) begin
          state_nxt = ST_FAULT;
          fault_nxt = FC_ABORT;
        end else if (cpu_halted) begin
          state_nxt = ST_HALTED;
        end else if (exec_wd_hit) begin
          state_nxt = ST_FAULT;
          fault_nxt = FC_EXEC;
        end
      end
      ST_HALTED, ST_FAULT: begin
        if (start) begin
          state_nxt = RESTART_STATE;
          fault_nxt = FC_NONE;
          restart   = 1'b1;
        end else if (dbg_req) begin
          state_nxt = ST_DEBUG;
        end
      end
      ST_DEBUG: begin
        if (dbg_second) state_nxt = ret_state;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Control registers, counters and the debug handshake.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cpu_execute <= 1'b0;
      cpu_restart <= 1'b0;
      fault_code  <= FC_NONE;
      timer       <= '0;
      exec_cycles <= '0;
      ret_state   <= ST_IDLE;
      dbg_second  <= 1'b0;
      dbg_rd      <= 1'b0;
      dbg_ack     <= 1'b0;
      dbg_rdata   <= '0;
    end else begin
      cpu_execute <= (state_nxt == ST_EXECUTING);
      cpu_restart <= restart;
      fault_code  <= fault_nxt;

      if (state == ST_LOADING && state_nxt == ST_LOADING) timer <= timer + 32'd1;
      else                                                 timer <= '0;

      if ((state == ST_IDLE && state_nxt == ST_LOADING) || restart)
        exec_cycles <= '0;
      else if (state == ST_EXECUTING && exec_cycles != '1)
        exec_cycles <= exec_cycles + CYCLE_W'(1);

      if (state != ST_DEBUG && state_nxt == ST_DEBUG) ret_state <= state;

      dbg_second <= (state == ST_DEBUG) && !dbg_second;
      if (state == ST_DEBUG && !dbg_second) dbg_rd <= !dbg_we;

      dbg_ack <= (state == ST_DEBUG) && dbg_second;
      if (state == ST_DEBUG && dbg_second && dbg_rd) dbg_rdata <= mem_rdata;
    end
  end

  // RAM port mux: only the owner of the current state may touch memory.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    case (state)
      ST_LOADING: begin
        mem_addr  = loader_addr;
        mem_wdata = loader_wdata;
        mem_we    = loader_we;
      end
      ST_EXECUTING: begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = cpu_we;
        mem_re    = cpu_re;
      end
      ST_DEBUG: begin
        if (!dbg_second) begin
          mem_addr  = dbg_addr;
          mem_wdata = dbg_wdata;
          mem_we    = dbg_we;
          mem_re    = !dbg_we;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_system_sequencer.sv
// Self-checking bench for system_sequencer: randomised scenario lengths and
// data, with expectations derived from the sequencing rules by arithmetic and
// a bench-side memory image.
module tb_system_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        start, abort, load_complete;
  logic [7:0]  loader_addr, cpu_addr, dbg_addr;
  logic [15:0] loader_wdata, cpu_wdata, dbg_wdata;
  logic        loader_we, cpu_we, cpu_re, cpu_halted, dbg_req, dbg_we;
  logic [15:0] mem_rdata;

  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we, mem_re, start_load, cpu_execute, cpu_restart, dbg_ack;
  logic [15:0] dbg_rdata;
  logic [2:0]  state_out;
  logic [1:0]  fault_code;
  logic [31:0] exec_cycles;

  // Second instance: reload on restart, narrow saturating cycle counter.
  logic [7:0]  b_mem_addr;
  logic [15:0] b_mem_wdata;
  logic        b_mem_we, b_mem_re, b_start_load, b_cpu_execute, b_cpu_restart, b_dbg_ack;
  logic [15:0] b_dbg_rdata;
  logic [2:0]  b_state_out;
  logic [1:0]  b_fault_code;
  logic [3:0]  b_exec_cycles;

  int checks = 0;
  int errors = 0;

  system_sequencer #(.MEM_ADDR_SIZE(8), .WORD_SIZE(16), .CYCLE_W(32),
    .LOAD_TIMEOUT(8), .EXEC_TIMEOUT(16), .RELOAD_ON_RESTART(0)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .load_complete(load_complete), .loader_addr(loader_addr),
    .loader_wdata(loader_wdata), .loader_we(loader_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_re(cpu_re),
    .cpu_halted(cpu_halted), .dbg_req(dbg_req), .dbg_we(dbg_we),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .mem_rdata(mem_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_re(mem_re), .start_load(start_load), .cpu_execute(cpu_execute),
    .cpu_restart(cpu_restart), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .state_out(state_out), .fault_code(fault_code), .exec_cycles(exec_cycles));

  system_sequencer #(.MEM_ADDR_SIZE(8), .WORD_SIZE(16), .CYCLE_W(4),
    .LOAD_TIMEOUT(8), .EXEC_TIMEOUT(16), .RELOAD_ON_RESTART(1)) dut_b (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .load_complete(load_complete), .loader_addr(loader_addr),
    .loader_wdata(loader_wdata), .loader_we(loader_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_re(cpu_re),
    .cpu_halted(cpu_halted), .dbg_req(dbg_req), .dbg_we(dbg_we),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .mem_rdata(mem_rdata),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_we(b_mem_we),
    .mem_re(b_mem_re), .start_load(b_start_load), .cpu_execute(b_cpu_execute),
    .cpu_restart(b_cpu_restart), .dbg_ack(b_dbg_ack), .dbg_rdata(b_dbg_rdata),
    .state_out(b_state_out), .fault_code(b_fault_code), .exec_cycles(b_exec_cycles));

  always #5 clock = ~clock;

  // Synchronous RAM attached to the first instance's port; read data a cycle later.
  logic [15:0] ram [0:255];
  always @(posedge clock) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= mem_re ? ram[mem_addr] : 16'h0000;
  end

  // Expected memory image of debug writes, kept by the bench.
  logic [15:0] exp_mem [0:255];

  task automatic tick;
    @(posedge clock);
    #2;
  endtask

  task automatic clear_inputs;
    start = 0; abort = 0; load_complete = 0;
    loader_addr = 0; loader_wdata = 0; loader_we = 0;
    cpu_addr = 0; cpu_wdata = 0; cpu_we = 0; cpu_re = 0; cpu_halted = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
  endtask

  task automatic do_reset;
    clear_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  // Start and spend n cycles in LOADING, load_complete in the last one.
  task automatic run_to_exec(input int n);
    start = 1;
    tick();
    start = 0;
    repeat (n - 1) tick();
    load_complete = 1;
    tick();
    load_complete = 0;
  endtask

  // One debug access from a resting state; returns what was observed.
  task automatic dbg_access(input logic we, input logic [7:0] a, input logic [15:0] d,
                            output logic [2:0] st1, output logic we1, output logic re1,
                            output logic [7:0] a1, output logic ack2, output logic ack3,
                            output logic [2:0] st3, output logic [15:0] rd3);
    dbg_req = 1; dbg_we = we; dbg_addr = a; dbg_wdata = d;
    tick();
    #1;
    st1 = state_out; we1 = mem_we; re1 = mem_re; a1 = mem_addr;
    dbg_req = 0;
    tick();
    ack2 = dbg_ack;
    tick();
    ack3 = dbg_ack; st3 = state_out; rd3 = dbg_rdata;
  endtask

  task automatic test_reset;
    clear_inputs();
    reset = 1;
    #1;
    checks++; if (state_out !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_out); end
    checks++; if ({cpu_execute, cpu_restart, dbg_ack} !== 3'b000) begin errors++; $display("FAIL reset_pulses: got %b expected 000", {cpu_execute, cpu_restart, dbg_ack}); end
    checks++; if (dbg_rdata !== 16'h0 || fault_code !== 2'd0 || exec_cycles !== 32'd0) begin errors++; $display("FAIL reset_regs: got rdata=%0h fc=%0d cyc=%0d expected 0 0 0", dbg_rdata, fault_code, exec_cycles); end
    checks++; if ({mem_we, mem_re, start_load} !== 3'b000) begin errors++; $display("FAIL reset_mem: got %b expected 000", {mem_we, mem_re, start_load}); end
    tick();
    reset = 0;
    tick();
    checks++; if (state_out !== 3'd0) begin errors++; $display("FAIL idle_hold: got %0d expected 0", state_out); end
  endtask

  task automatic test_load_exec;
    int L, H;
    for (int r = 0; r < 5; r++) begin
      L = (r == 0) ? 6 : (r == 1) ? 8 : $urandom_range(1, 8);
      H = (r == 0) ? 10 : (r == 1) ? 16 : $urandom_range(1, 16);
      do_reset();
      start = 1;
      tick();
      start = 0;
      checks++; if (state_out !== 3'd1 || start_load !== 1'b1 || cpu_execute !== 1'b0) begin errors++; $display("FAIL load_entry: got st=%0d sl=%b ce=%b expected 1 1 0", state_out, start_load, cpu_execute); end
      for (int i = 1; i <= L; i++) begin
        loader_addr = 8'($urandom); loader_wdata = 16'($urandom);
        loader_we = (i <= 4) ? 1'b1 : 1'($urandom_range(0, 1));
        cpu_addr = 8'($urandom); cpu_we = 1; cpu_re = 1;
        load_complete = (i == L);
        #1;
        checks++; if (mem_addr !== loader_addr || mem_wdata !== loader_wdata || mem_we !== loader_we || mem_re !== 1'b0 || state_out !== 3'd1) begin
          errors++; $display("FAIL load_mux: got a=%0h d=%0h we=%b re=%b st=%0d expected a=%0h d=%0h we=%b re=0 st=1", mem_addr, mem_wdata, mem_we, mem_re, state_out, loader_addr, loader_wdata, loader_we);
        end
        tick();
      end
      load_complete = 0; loader_we = 0;
      checks++; if (state_out !== 3'd2 || cpu_execute !== 1'b1 || start_load !== 1'b0) begin errors++; $display("FAIL exec_entry L=%0d: got st=%0d ce=%b sl=%b expected 2 1 0", L, state_out, cpu_execute, start_load); end
      for (int i = 1; i <= H; i++) begin
        cpu_addr = 8'($urandom); cpu_wdata = 16'($urandom);
        cpu_we = 1'($urandom_range(0, 1)); cpu_re = 1'($urandom_range(0, 1));
        cpu_halted = (i == H);
        #1;
        checks++; if (mem_addr !== cpu_addr || mem_wdata !== cpu_wdata || mem_we !== cpu_we || mem_re !== cpu_re || exec_cycles !== 32'(i - 1) || state_out !== 3'd2) begin
          errors++; $display("FAIL exec_mux: got a=%0h we=%b re=%b cyc=%0d st=%0d expected a=%0h we=%b re=%b cyc=%0d st=2", mem_addr, mem_we, mem_re, exec_cycles, state_out, cpu_addr, cpu_we, cpu_re, i - 1);
        end
        tick();
      end
      cpu_halted = 0; cpu_we = 0; cpu_re = 0;
      #1;
      checks++; if (state_out !== 3'd3 || cpu_execute !== 1'b0 || fault_code !== 2'd0 || mem_we !== 1'b0) begin errors++; $display("FAIL halted H=%0d: got st=%0d ce=%b fc=%0d we=%b expected 3 0 0 0", H, state_out, cpu_execute, fault_code, mem_we); end
      checks++; if (exec_cycles !== 32'(H)) begin errors++; $display("FAIL exec_count: got %0d expected %0d", exec_cycles, H); end
      checks++; if (b_exec_cycles !== 4'((H > 15) ? 15 : H)) begin errors++; $display("FAIL exec_sat: got %0d expected %0d", b_exec_cycles, (H > 15) ? 15 : H); end
      tick();
      checks++; if (exec_cycles !== 32'(H) || state_out !== 3'd3) begin errors++; $display("FAIL halted_hold: got cyc=%0d st=%0d expected %0d 3", exec_cycles, state_out, H); end
    end
  endtask

  task automatic test_load_timeout;
    do_reset();
    start = 1;
    tick();
    start = 0;
    for (int i = 1; i <= 8; i++) begin
      checks++; if (state_out !== 3'd1) begin errors++; $display("FAIL load_wait cycle %0d: got %0d expected 1", i, state_out); end
      loader_we = 1; loader_addr = 8'($urandom); loader_wdata = 16'($urandom);
      tick();
    end
    #1;
    checks++; if (state_out !== 3'd4 || fault_code !== 2'd1) begin errors++; $display("FAIL load_timeout: got st=%0d fc=%0d expected 4 1", state_out, fault_code); end
    checks++; if (mem_we !== 1'b0 || start_load !== 1'b0) begin errors++; $display("FAIL load_timeout_mem: got we=%b sl=%b expected 0 0", mem_we, start_load); end
    loader_we = 0;
  endtask

  task automatic test_exec_timeout;
    do_reset();
    run_to_exec($urandom_range(1, 5));
    for (int i = 1; i <= 16; i++) begin
      checks++; if (state_out !== 3'd2) begin errors++; $display("FAIL exec_wait cycle %0d: got %0d expected 2", i, state_out); end
      tick();
    end
    checks++; if (state_out !== 3'd4 || fault_code !== 2'd2 || cpu_execute !== 1'b0) begin errors++; $display("FAIL exec_timeout: got st=%0d fc=%0d ce=%b expected 4 2 0", state_out, fault_code, cpu_execute); end
    checks++; if (exec_cycles !== 32'd16 || b_exec_cycles !== 4'd15 || b_state_out !== 3'd4) begin errors++; $display("FAIL exec_timeout_cnt: got %0d/%0d bst=%0d expected 16/15 4", exec_cycles, b_exec_cycles, b_state_out); end
  endtask

  task automatic test_abort_restart;
    int K;
    K = $urandom_range(1, 10);
    do_reset();
    run_to_exec(1);
    repeat (K - 1) tick();
    abort = 1; cpu_halted = 1;
    tick();
    abort = 0; cpu_halted = 0;
    checks++; if (state_out !== 3'd4 || fault_code !== 2'd3 || exec_cycles !== 32'(K)) begin errors++; $display("FAIL abort_exec: got st=%0d fc=%0d cyc=%0d expected 4 3 %0d", state_out, fault_code, exec_cycles, K); end
    tick();
    tick();
    checks++; if (fault_code !== 2'd3 || exec_cycles !== 32'(K) || cpu_restart !== 1'b0) begin errors++; $display("FAIL fault_hold: got fc=%0d cyc=%0d rs=%b expected 3 %0d 0", fault_code, exec_cycles, cpu_restart, K); end
    start = 1;
    tick();
    start = 0;
    checks++; if (state_out !== 3'd2 || cpu_restart !== 1'b1 || fault_code !== 2'd0 || exec_cycles !== 32'd0 || cpu_execute !== 1'b1) begin
      errors++; $display("FAIL restart_exec: got st=%0d rs=%b fc=%0d cyc=%0d ce=%b expected 2 1 0 0 1", state_out, cpu_restart, fault_code, exec_cycles, cpu_execute);
    end
    checks++; if (b_state_out !== 3'd1 || b_cpu_restart !== 1'b1 || b_fault_code !== 2'd0) begin errors++; $display("FAIL restart_reload: got st=%0d rs=%b fc=%0d expected 1 1 0", b_state_out, b_cpu_restart, b_fault_code); end
    tick();
    checks++; if (cpu_restart !== 1'b0 || b_cpu_restart !== 1'b0 || exec_cycles !== 32'd1) begin errors++; $display("FAIL restart_pulse: got rs=%b/%b cyc=%0d expected 0/0 1", cpu_restart, b_cpu_restart, exec_cycles); end
    do_reset();
    start = 1;
    tick();
    start = 0;
    abort = 1; load_complete = 1;
    tick();
    abort = 0; load_complete = 0;
    checks++; if (state_out !== 3'd4 || fault_code !== 2'd3) begin errors++; $display("FAIL abort_load: got st=%0d fc=%0d expected 4 3", state_out, fault_code); end
  endtask

  task automatic test_debug;
    logic [2:0] st1, st3; logic we1, re1, ack2, ack3; logic [7:0] a1; logic [15:0] rd3;
    logic [15:0] exp_rdata, d;
    logic [7:0] a;
    logic [7:0] written [$];
    do_reset();
    run_to_exec(1);
    cpu_halted = 1;
    tick();
    cpu_halted = 0;
    dbg_access(1'b1, 8'h10, 16'hBEEF, st1, we1, re1, a1, ack2, ack3, st3, rd3);
    checks++; if (st1 !== 3'd5 || we1 !== 1'b1 || re1 !== 1'b0 || a1 !== 8'h10) begin errors++; $display("FAIL dbg_wr_issue: got st=%0d we=%b re=%b a=%0h expected 5 1 0 10", st1, we1, re1, a1); end
    checks++; if (ack2 !== 1'b0 || ack3 !== 1'b1 || st3 !== 3'd3 || rd3 !== 16'h0) begin errors++; $display("FAIL dbg_wr_ack: got ack=%b%b st=%0d rd=%0h expected 01 3 0", ack2, ack3, st3, rd3); end
    dbg_access(1'b0, 8'h10, 16'h0, st1, we1, re1, a1, ack2, ack3, st3, rd3);
    checks++; if (st1 !== 3'd5 || we1 !== 1'b0 || re1 !== 1'b1) begin errors++; $display("FAIL dbg_rd_issue: got st=%0d we=%b re=%b expected 5 0 1", st1, we1, re1); end
    checks++; if (ack3 !== 1'b1 || st3 !== 3'd3 || rd3 !== 16'hBEEF) begin errors++; $display("FAIL dbg_rd_data: got ack=%b st=%0d rd=%0h expected 1 3 beef", ack3, st3, rd3); end
    tick();
    checks++; if (dbg_ack !== 1'b0 || state_out !== 3'd3) begin errors++; $display("FAIL dbg_ack_pulse: got ack=%b st=%0d expected 0 3", dbg_ack, state_out); end
    exp_mem[8'h10] = 16'hBEEF;
    written.push_back(8'h10);
    exp_rdata = 16'hBEEF;
    // Random accesses from IDLE; dbg_rdata survives a reset only as zero.
    do_reset();
    exp_rdata = 16'h0;
    for (int k = 0; k < 6; k++) begin
      a = 8'($urandom); d = 16'($urandom);
      dbg_access(1'b1, a, d, st1, we1, re1, a1, ack2, ack3, st3, rd3);
      exp_mem[a] = d;
      written.push_back(a);
      checks++; if (st1 !== 3'd5 || we1 !== 1'b1 || a1 !== a || ack3 !== 1'b1 || st3 !== 3'd0 || rd3 !== exp_rdata) begin
        errors++; $display("FAIL dbg_rand_wr: got st=%0d we=%b a=%0h ack=%b ret=%0d rd=%0h expected 5 1 %0h 1 0 %0h", st1, we1, a1, ack3, st3, rd3, a, exp_rdata);
      end
      a = written[$urandom_range(0, written.size() - 1)];
      dbg_access(1'b0, a, 16'h0, st1, we1, re1, a1, ack2, ack3, st3, rd3);
      exp_rdata = exp_mem[a];
      checks++; if (re1 !== 1'b1 || a1 !== a || ack3 !== 1'b1 || st3 !== 3'd0 || rd3 !== exp_rdata) begin
        errors++; $display("FAIL dbg_rand_rd: got re=%b a=%0h ack=%b ret=%0d rd=%0h expected 1 %0h 1 0 %0h", re1, a1, ack3, st3, rd3, a, exp_rdata);
      end
    end
  endtask

  task automatic test_back_to_back;
    do_reset();
    run_to_exec(1);
    abort = 1;
    tick();
    abort = 0;
    dbg_req = 1; dbg_we = 0; dbg_addr = 8'h10;
    tick();
    checks++; if (state_out !== 3'd5) begin errors++; $display("FAIL b2b_enter: got %0d expected 5", state_out); end
    start = 1; abort = 1;
    tick();
    checks++; if (state_out !== 3'd5 || fault_code !== 2'd3) begin errors++; $display("FAIL dbg_ignore_start: got st=%0d fc=%0d expected 5 3", state_out, fault_code); end
    tick();
    start = 0; abort = 0;
    checks++; if (state_out !== 3'd4 || dbg_ack !== 1'b1 || dbg_rdata !== 16'hBEEF) begin errors++; $display("FAIL b2b_first: got st=%0d ack=%b rd=%0h expected 4 1 beef", state_out, dbg_ack, dbg_rdata); end
    tick();
    checks++; if (state_out !== 3'd5 || dbg_ack !== 1'b0) begin errors++; $display("FAIL b2b_second: got st=%0d ack=%b expected 5 0", state_out, dbg_ack); end
    dbg_req = 0;
    tick();
    tick();
    checks++; if (state_out !== 3'd4 || dbg_ack !== 1'b1 || fault_code !== 2'd3) begin errors++; $display("FAIL b2b_return: got st=%0d ack=%b fc=%0d expected 4 1 3", state_out, dbg_ack, fault_code); end
  endtask

  task automatic test_dbg_in_exec;
    do_reset();
    run_to_exec(2);
    dbg_req = 1; dbg_we = 1; dbg_addr = 8'h55; dbg_wdata = 16'h1234;
    for (int i = 0; i < 4; i++) begin
      cpu_addr = 8'($urandom); cpu_we = 0; cpu_re = 1;
      #1;
      checks++; if (mem_addr !== cpu_addr || mem_we !== 1'b0 || mem_re !== 1'b1) begin errors++; $display("FAIL dbg_exec_mux: got a=%0h we=%b re=%b expected %0h 0 1", mem_addr, mem_we, mem_re, cpu_addr); end
      tick();
      checks++; if (dbg_ack !== 1'b0 || state_out !== 3'd2) begin errors++; $display("FAIL dbg_exec_ignored: got ack=%b st=%0d expected 0 2", dbg_ack, state_out); end
    end
    dbg_req = 0; cpu_re = 0;
  endtask

  task automatic test_async_reset;
    do_reset();
    start = 1;
    tick();
    start = 0;
    loader_we = 1; loader_addr = 8'h33;
    #1;
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL pre_reset_we: got %b expected 1", mem_we); end
    #2;
    reset = 1;
    #1;
    checks++; if (state_out !== 3'd0 || mem_we !== 1'b0 || cpu_execute !== 1'b0 || start_load !== 1'b0 || mem_addr !== 8'h0) begin
      errors++; $display("FAIL async_reset_load: got st=%0d we=%b ce=%b sl=%b a=%0h expected 0 0 0 0 0", state_out, mem_we, cpu_execute, start_load, mem_addr);
    end
    tick();
    clear_inputs();
    reset = 0;
    run_to_exec(2);
    repeat (3) tick();
    #3;
    checks++; if (cpu_execute !== 1'b1) begin errors++; $display("FAIL pre_reset_exec: got %b expected 1", cpu_execute); end
    reset = 1;
    #1;
    checks++; if (state_out !== 3'd0 || cpu_execute !== 1'b0 || exec_cycles !== 32'd0) begin errors++; $display("FAIL async_reset_exec: got st=%0d ce=%b cyc=%0d expected 0 0 0", state_out, cpu_execute, exec_cycles); end
    tick();
    reset = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_load_exec();
    test_load_timeout();
    test_exec_timeout();
    test_abort_restart();
    test_debug();
    test_back_to_back();
    test_dbg_in_exec();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
